top_level: RTL and testbench
============================

TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 Parameter CLK_HZ, 100000000, input clock frequency in Hz.
REQ-002 Parameter TICK_DIV, CLK_HZ/100, clock cycles per 0.01 s count increment (minimum 2).
REQ-003 Parameter DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a button level change (minimum 2).
REQ-004 Parameter SCAN_DIV, 100000, clock cycles per display digit slot (minimum 2).
REQ-005 clk  input  1  system clock; all logic SHALL sit in one clock domain on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 button0  input  1  start/stop push button, asynchronous, active-high.
REQ-008 button1  input  1  clear push button, asynchronous, active-high.
REQ-009 seg  output  7  segment drive, active-low: seg[0]=a, seg[1]=b, ... seg[6]=g.
REQ-010 an  output  4  digit anode enables, active-low: an[0] is the rightmost digit.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-012 A debounced 0->1 transition SHALL produce exactly one single-cycle press pulse; a held button SHALL produce no further pulses; release SHALL produce none.
REQ-013 The state machine SHALL have states STOPPED and RUNNING; a button0 pulse SHALL toggle the state, taking effect on the next clock edge.
REQ-014 In RUNNING, the prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on wrap; in STOPPED, the prescaler SHALL hold its value.
REQ-015 The time count SHALL be 4 BCD digits SS.cc (d3 d2 = seconds 00-99, d1 d0 = hundredths 00-99); each tick SHALL add 0.01 s with decimal carry.
REQ-016 At 99.99, the next tick SHALL wrap the count to 00.00 and the stopwatch SHALL keep running.
REQ-017 A button1 pulse SHALL clear the count and the prescaler to 0 and force STOPPED on the next edge.
REQ-018 If button0 and button1 pulses occur in the same cycle, button1 SHALL take priority: the count is cleared and the state is STOPPED.
REQ-019 If a tick coincides with a button0 stop pulse, the tick SHALL be applied and then the stopwatch SHALL stop.
REQ-020 The display SHALL scan digits 0,1,2,3,0,... with each digit active for SCAN_DIV cycles and exactly one an bit low at a time; an[i] SHALL show digit di.
REQ-021 The seg patterns SHALL be the standard hex patterns for 0-9 (active-low; "0" = 7'b1000000, "1" = 7'b1111001); seg and an SHALL be registered and change together.
REQ-022 Display scanning SHALL be independent of the RUNNING/STOPPED state.

Reset
REQ-023 While rst=1: state = STOPPED, count = 00.00, prescaler = 0, scan counter = 0, debouncer and synchronizer flops = 0, an = 4'b1111, seg = 7'b1111111.
REQ-024 On the first edge after rst is released, scanning SHALL start at digit 0 (an = 4'b1110).
REQ-025 A reset asserted while RUNNING SHALL abort operation immediately; no press pulse SHALL be generated from a button held across reset until it is released and pressed again.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN: if defined, d3 SHALL be blanked (seg = 7'b1111111) whenever it is 0; if undefined, all four digits SHALL always be displayed.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4, SCAN_DIV=4)
REQ-027 Reset for 10 cycles, then release -> an = 4'b1110, seg = 7'b1000000, count 00.00, STOPPED.
REQ-028 Hold button0 for 20 cycles, release, wait 1000 cycles -> exactly one start; count = 01.00 (+/-1 tick); then hold button0 for 20 cycles -> count frozen for the next 500 cycles.
REQ-029 Hold button1 for 20 cycles while STOPPED at nonzero count -> all digits show 0, state STOPPED.
REQ-030 Force the count to 99.99 and start -> after 10 cycles the count is 00.00 and still incrementing.
REQ-031 Pulse button0 and button1 in the same cycle while RUNNING -> count 00.00, STOPPED.
REQ-032 Apply a 2-cycle glitch on button0 -> no state change; with LEADING_ZERO_BLANK_EN defined, count 05.00 -> an[3] slot shows seg = 7'b1111111.

Source files
------------

// File: rtl/top_level.sv
// Stopwatch SS.cc with debounced start/stop (button0) and clear (button1), on a multiplexed 4-digit 7-seg display.
// Build option: define LEADING_ZERO_BLANK_EN to blank the tens-of-seconds digit when it is zero.
module sw_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic          db;
    logic          armed;
    logic [1:0]    fill;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (s2 != db) && (cnt == CW'(CYCLES - 1));

    // fill marks when s2 carries a real button sample rather than a reset zero;
    // armed stays low until a genuine low level is seen, so a button held across reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            db    <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1   <= level;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
            if (s2 == db || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                db <= s2;
            end
            press <= accept && s2 && armed;
            if (fill[1] && !s2 && !db) begin
                armed <= 1'b1;
            end
        end
    end
endmodule

module top_level #(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_DIV        = CLK_HZ / 100,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_DIV        = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button0,
    input  logic       button1,
    output logic [6:0] seg,
    output logic [3:0] an
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           running;
    logic           p0;
    logic           p1;
    logic           tick;
    logic [PW-1:0]  presc;
    logic [3:0][3:0] count;
    logic [3:0][3:0] count_inc;
    logic           carry;
    logic [SW-1:0]  scan_cnt;
    logic [1:0]     scan_digit;
    logic [3:0]     cur_digit;
    logic [6:0]     cur_seg;

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        case (d)
            4'd0:    seg_pat = 7'b1000000;
            4'd1:    seg_pat = 7'b1111001;
            4'd2:    seg_pat = 7'b0100100;
            4'd3:    seg_pat = 7'b0110000;
            4'd4:    seg_pat = 7'b0011001;
            4'd5:    seg_pat = 7'b0010010;
            4'd6:    seg_pat = 7'b0000010;
            4'd7:    seg_pat = 7'b1111000;
            4'd8:    seg_pat = 7'b0000000;
            4'd9:    seg_pat = 7'b0010000;
            default: seg_pat = 7'b1111111;
        endcase
    endfunction

    sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk   (clk),
        .rst   (rst),
        .level (button0),
        .press (p0)
    );

    sw_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk   (clk),
        .rst   (rst),
        .level (button1),
        .press (p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOPPED;
        end else begin
            state <= state_next;
        end
    end

    // Clear wins over start/stop when both pulses land in the same cycle.
    always_comb begin
        state_next = state;
        if (p1) begin
            state_next = STOPPED;
        end else if (p0) begin
            state_next = (state == STOPPED) ? RUNNING : STOPPED;
        end
    end

    always_comb begin
        running = (state == RUNNING);
    end

    assign tick = running && (presc == PW'(TICK_DIV - 1));

    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[i] == 4'd9) begin
                    count_inc[i] = 4'd0;
                end else begin
                    count_inc[i] = count[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    // A stop pulse coinciding with a tick still lets the tick land.
    always_ff @(posedge clk) begin
        if (rst || p1) begin
            presc <= '0;
            count <= '0;
        end else if (running) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                count <= count_inc;
            end
        end
    end

    always_comb begin
        cur_digit = count[scan_digit];
        cur_seg   = seg_pat(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (scan_digit == 2'd3 && cur_digit == 4'd0) begin
            cur_seg = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt   <= '0;
            scan_digit <= 2'd0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << scan_digit);
            seg <= cur_seg;
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt   <= '0;
                scan_digit <= scan_digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: lane 0 uses TICK_DIV=10, lane 1 uses TICK_DIV=2 so the 99.99 wrap is reachable.
module tb_top_level;
    localparam int DB = 4;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       b0  [2];
    logic       b1  [2];
    logic [6:0] seg [2];
    logic [3:0] an  [2];
    logic       chk [2];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: pat = 7'b1000000;
            1: pat = 7'b1111001;
            2: pat = 7'b0100100;
            3: pat = 7'b0110000;
            4: pat = 7'b0011001;
            5: pat = 7'b0010010;
            6: pat = 7'b0000010;
            7: pat = 7'b1111000;
            8: pat = 7'b0000000;
            9: pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
    endfunction

    function automatic int p10(input int k);
        case (k)
            0: p10 = 1;
            1: p10 = 10;
            2: p10 = 100;
            default: p10 = 1000;
        endcase
    endfunction

    function automatic int seg_digit(input logic [6:0] s);
        seg_digit = 15;
        if (s == 7'b1111111) seg_digit = 0;
        for (int d = 0; d < 10; d++) begin
            if (s == pat(d)) seg_digit = d;
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int TD = (g == 0) ? 10 : 2;
        localparam logic [DB-1:0] DB_ONES = {DB{1'b1}};

        top_level #(
            .CLK_HZ          (1000),
            .TICK_DIV        (TD),
            .DEBOUNCE_CYCLES (DB),
            .SCAN_DIV        (SD)
        ) dut (
            .clk     (clk),
            .rst     (rst[g]),
            .button0 (b0[g]),
            .button1 (b1[g]),
            .seg     (seg[g]),
            .an      (an[g])
        );

        // Model: time is total running cycles since the last clear; the display value is derived arithmetically.
        int          edges = 0;
        int          m_cyc = 0;
        logic        m_run = 1'b0;
        logic [3:0]  m_an = 4'hF;
        logic [6:0]  m_seg = 7'h7F;
        logic [31:0] raw_h [2];
        logic [31:0] syn_h [2];
        logic        dbm [2];
        logic        arm [2];
        logic        pm [2];
        int          slot;
        int          val;
        int          dig;
        logic        btn;
        logic        syn;

        always @(posedge clk) begin
            if (rst[g]) begin
                edges = 0;
                m_cyc = 0;
                m_run = 1'b0;
                m_an  = 4'hF;
                m_seg = 7'h7F;
                for (int k = 0; k < 2; k++) begin
                    raw_h[k] = '0;
                    syn_h[k] = '0;
                    dbm[k]   = 1'b0;
                    arm[k]   = 1'b0;
                    pm[k]    = 1'b0;
                end
            end else begin
                edges++;
                slot = ((edges - 1) / SD) % 4;
                val  = (m_cyc / TD) % 10000;
                dig  = (val / p10(slot)) % 10;
                m_an = 4'hF;
                m_an[slot] = 1'b0;
                m_seg = pat(dig);
`ifdef LEADING_ZERO_BLANK_EN
                if (slot == 3 && dig == 0) m_seg = 7'h7F;
`endif
                if (pm[1]) begin
                    m_cyc = 0;
                    m_run = 1'b0;
                end else begin
                    if (m_run) m_cyc++;
                    if (pm[0]) m_run = !m_run;
                end
                for (int k = 0; k < 2; k++) begin
                    btn = (k == 0) ? b0[g] : b1[g];
                    syn = (edges >= 3) ? raw_h[k][1] : 1'b0;
                    raw_h[k] = {raw_h[k][30:0], btn};
                    syn_h[k] = {syn_h[k][30:0], syn};
                    pm[k] = 1'b0;
                    if (syn_h[k][DB-1:0] == (dbm[k] ? {DB{1'b0}} : DB_ONES)) begin
                        pm[k]  = !dbm[k] && arm[k];
                        dbm[k] = !dbm[k];
                    end
                    if (edges >= 3 && !syn && !dbm[k]) arm[k] = 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            if (chk[g]) begin
                total++;
                if (an[g] !== m_an || seg[g] !== m_seg) begin
                    bad++;
                    $display("FAIL lane%0d display @%0t: an=%b seg=%b expected an=%b seg=%b",
                             g, $time, an[g], seg[g], m_an, m_seg);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic hold(input int l, input int which, input int n);
        if (which[0]) b0[l] = 1'b1;
        if (which[1]) b1[l] = 1'b1;
        repeat (n) @(negedge clk);
        b0[l] = 1'b0;
        b1[l] = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_disp(input int l, output int v, output int blank3);
        int d [4];
        for (int i = 0; i < 4; i++) d[i] = 15;
        blank3 = 0;
        repeat (4 * SD + 1) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (an[l] == ~(4'b0001 << i)) begin
                    d[i] = seg_digit(seg[l]);
                    if (i == 3 && seg[l] == 7'b1111111) blank3 = 1;
                end
            end
        end
        v = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    endtask

    task automatic reset_lane(input int l);
        rst[l] = 1'b1;
        @(negedge clk);
        chk[l] = 1'b1;
        wait_cyc(9);
        check($sformatf("lane%0d reset an", l), int'(an[l]), 4'b1111);
        check($sformatf("lane%0d reset seg", l), int'(seg[l]), 7'b1111111);
        rst[l] = 1'b0;
        @(negedge clk);
        check($sformatf("lane%0d first an", l), int'(an[l]), 4'b1110);
        check($sformatf("lane%0d first seg", l), int'(seg[l]), 7'b1000000);
    endtask

    task automatic seq_main();
        int v;
        int bl;
        reset_lane(0);
        read_disp(0, v, bl);
        check("count after reset", v, 0);
        hold(0, 1, 20);
        wait_cyc(980);
        hold(0, 1, 20);
        wait_cyc(20);
        read_disp(0, v, bl);
        check("count after 1000 running cycles", v, 100);
        wait_cyc(500);
        read_disp(0, v, bl);
        check("count frozen when stopped", v, 100);
        hold(0, 2, 20);
        wait_cyc(20);
        read_disp(0, v, bl);
        check("clear while stopped", v, 0);
        wait_cyc(100);
        read_disp(0, v, bl);
        check("stays stopped after clear", v, 0);
        hold(0, 1, 2);
        wait_cyc(300);
        read_disp(0, v, bl);
        check("glitch ignored", v, 0);
        hold(0, 1, 20);
        wait_cyc(200);
        hold(0, 3, 20);
        wait_cyc(20);
        read_disp(0, v, bl);
        check("simultaneous press clears", v, 0);
        wait_cyc(200);
        read_disp(0, v, bl);
        check("simultaneous press stops", v, 0);
        hold(0, 1, 20);
        wait_cyc(100);
        b0[0] = 1'b1;
        rst[0] = 1'b1;
        wait_cyc(10);
        rst[0] = 1'b0;
        wait_cyc(30);
        b0[0] = 1'b0;
        wait_cyc(200);
        read_disp(0, v, bl);
        check("held across reset gives no start", v, 0);
        hold(0, 1, 20);
        wait_cyc(480);
        hold(0, 1, 20);
        wait_cyc(20);
        read_disp(0, v, bl);
        check("restart after reset", v, 50);
    endtask

    task automatic seq_wrap();
        int v;
        int bl;
        int exp_blank;
        b1[1] = 1'b0;
        reset_lane(1);
        hold(1, 1, 20);
        wait_cyc(980);
        hold(1, 1, 20);
        wait_cyc(20);
        read_disp(1, v, bl);
        check("fast lane 05.00", v, 500);
`ifdef LEADING_ZERO_BLANK_EN
        exp_blank = 1;
`else
        exp_blank = 0;
`endif
        check("d3 blanking at 05.00", bl, exp_blank);
        hold(1, 1, 20);
        wait_cyc(19000);
        hold(1, 1, 20);
        wait_cyc(20);
        read_disp(1, v, bl);
        check("count past 99.99 wrap", v, 10);
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            rst[l] = 1'b1;
            b0[l]  = 1'b0;
            b1[l]  = 1'b0;
            chk[l] = 1'b0;
        end
        fork
            seq_main();
            seq_wrap();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
